// File: rtl/ddr_rd_sched_if.sv
// ============================================================================
// Module  : ddr_rd_sched_if
// Purpose : Bus bundle between the DDR read scheduler, its requesters and the
//           AXI read-command driver.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface ddr_rd_sched_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 8
);
    logic                    start;
    logic [DATA_WIDTH-1:0]   cfg_word;
    logic                    cfg_vld;
    logic [3:0]              req;
    logic [4*LEN_WIDTH-1:0]  req_len;
    logic [3:0]              gnt;
    logic [3:0]              dat_vld;
    logic [3:0]              dat_rdy;
    logic [DATA_WIDTH-1:0]   dat;
    logic                    dat_last;
    logic                    rd_cmd_vld;
    logic                    rd_cmd_rdy;
    logic [ADDR_WIDTH-1:0]   rd_cmd_addr;
    logic [LEN_WIDTH-1:0]    rd_cmd_len;
    logic                    rd_dat_vld;
    logic                    rd_dat_rdy;
    logic [DATA_WIDTH-1:0]   rd_dat;

    // Scheduler side
    modport master (
        input  start, req, req_len, dat_rdy, rd_cmd_rdy, rd_dat_vld, rd_dat,
        output cfg_word, cfg_vld, gnt, dat_vld, dat, dat_last,
               rd_cmd_vld, rd_cmd_addr, rd_cmd_len, rd_dat_rdy
    );

    // Requesters / driver side
    modport slave (
        output start, req, req_len, dat_rdy, rd_cmd_rdy, rd_dat_vld, rd_dat,
        input  cfg_word, cfg_vld, gnt, dat_vld, dat, dat_last,
               rd_cmd_vld, rd_cmd_addr, rd_cmd_len, rd_dat_rdy
    );
endinterface

`default_nettype wire

// File: rtl/ddr_rd_sched.sv
// ============================================================================
// Module  : ddr_rd_sched
// Purpose : Config fetch plus round-robin DDR read-burst scheduler for four
//           requesters with per-requester streaming address pointers.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ddr_rd_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] CFG_ADDR    = ADDR_WIDTH'(32'h0800_0000),
    parameter logic [ADDR_WIDTH-1:0] ACT_BASE    = ADDR_WIDTH'(32'h0800_1000),
    parameter logic [ADDR_WIDTH-1:0] FLGACT_BASE = ADDR_WIDTH'(32'h0840_0000),
    parameter logic [ADDR_WIDTH-1:0] WEI_BASE    = ADDR_WIDTH'(32'h0841_0000),
    parameter logic [ADDR_WIDTH-1:0] FLGWEI_BASE = ADDR_WIDTH'(32'h0881_0000)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ddr_rd_sched_if.master    bus
);

    localparam int c_BEAT_BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] c_BASE [4] =
        '{ACT_BASE, FLGACT_BASE, WEI_BASE, FLGWEI_BASE};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG_CMD = 3'd1,
        S_CFG_DAT = 3'd2,
        S_ARB     = 3'd3,
        S_CMD     = 3'd4,
        S_DATA    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              gnt_q, gnt_d;
    logic [1:0]              gidx_q, gidx_d;
    logic [1:0]              rr_q, rr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [LEN_WIDTH:0]      out_q, out_d;
    logic [ADDR_WIDTH-1:0]   ptr_q [4];
    logic [ADDR_WIDTH-1:0]   ptr_d [4];
    logic [DATA_WIDTH-1:0]   cfg_word_q, cfg_word_d;
    logic                    cfg_vld_q, cfg_vld_d;

    logic                    cmd_vld;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [LEN_WIDTH-1:0]    cmd_len;
    logic                    rdat_rdy;
    logic [3:0]              dvld;
    logic                    dlast;
    logic                    found;
    logic [1:0]              cand;
    logic [1:0]              rr_idx;
    logic [LEN_WIDTH:0]      cmd_beats;
    logic [ADDR_WIDTH-1:0]   ptr_inc;

    assign bus.cfg_word    = cfg_word_q;
    assign bus.cfg_vld     = cfg_vld_q;
    assign bus.gnt         = gnt_q;
    assign bus.dat         = bus.rd_dat;
    assign bus.dat_vld     = dvld;
    assign bus.dat_last    = dlast;
    assign bus.rd_cmd_vld  = cmd_vld;
    assign bus.rd_cmd_addr = cmd_addr;
    assign bus.rd_cmd_len  = cmd_len;
    assign bus.rd_dat_rdy  = rdat_rdy;

    assign ptr_inc = ADDR_WIDTH'({1'b0, len_q} + (LEN_WIDTH+1)'(1))
                   * ADDR_WIDTH'(c_BEAT_BYTES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gidx_d     = gidx_q;
        rr_d       = rr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        cfg_word_d = cfg_word_q;
        cfg_vld_d  = cfg_vld_q;
        cmd_vld    = 1'b0;
        cmd_addr   = CFG_ADDR;
        cmd_len    = '0;
        rdat_rdy   = 1'b0;
        dvld       = '0;
        dlast      = 1'b0;
        found      = 1'b0;
        cand       = '0;
        rr_idx     = rr_q;

        // First requester at or after rr_q wins
        for (int i = 0; i < 4; i++) begin
            cand = rr_q + 2'(i);
            if (!found && bus.req[cand]) begin
                found  = 1'b1;
                rr_idx = cand;
            end
        end

        case (state_q)
            S_IDLE: ;
            S_CFG_CMD: begin
                // Leftover beats of an aborted burst are swallowed first
                if (out_q != '0) begin
                    rdat_rdy = 1'b1;
                end else begin
                    cmd_vld = 1'b1;
                    if (bus.rd_cmd_rdy) state_d = S_CFG_DAT;
                end
            end
            S_CFG_DAT: begin
                rdat_rdy = 1'b1;
                if (bus.rd_dat_vld) begin
                    cfg_word_d = bus.rd_dat;
                    cfg_vld_d  = 1'b1;
                    state_d    = S_ARB;
                end
            end
            S_ARB: begin
                if (found) begin
                    gnt_d   = 4'b0001 << rr_idx;
                    gidx_d  = rr_idx;
                    len_d   = bus.req_len[int'(rr_idx)*LEN_WIDTH +: LEN_WIDTH];
                    rr_d    = rr_idx + 2'd1;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                cmd_vld  = 1'b1;
                cmd_addr = ptr_q[gidx_q];
                cmd_len  = len_q;
                if (bus.rd_cmd_rdy) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                dvld     = gnt_q & {4{bus.rd_dat_vld}};
                rdat_rdy = bus.dat_rdy[gidx_q];
                dlast    = (cnt_q == len_q);
                if (bus.rd_dat_vld && bus.dat_rdy[gidx_q]) begin
                    if (cnt_q == len_q) begin
                        ptr_d[gidx_q] = ptr_q[gidx_q] + ptr_inc;
                        gnt_d         = '0;
                        state_d       = S_ARB;
                    end else begin
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_beats = (cmd_vld && bus.rd_cmd_rdy)
                  ? ({1'b0, cmd_len} + (LEN_WIDTH+1)'(1)) : '0;
        out_d = out_q + cmd_beats
              - ((bus.rd_dat_vld && rdat_rdy) ? (LEN_WIDTH+1)'(1) : '0);

        if (bus.start) begin
            state_d   = S_CFG_CMD;
            gnt_d     = '0;
            rr_d      = '0;
            cnt_d     = '0;
            cfg_vld_d = 1'b0;
            ptr_d     = c_BASE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q      <= '0;
            gidx_q     <= '0;
            rr_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            out_q      <= '0;
            ptr_q      <= c_BASE;
            cfg_word_q <= '0;
            cfg_vld_q  <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            gidx_q     <= gidx_d;
            rr_q       <= rr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            ptr_q      <= ptr_d;
            cfg_word_q <= cfg_word_d;
            cfg_vld_q  <= cfg_vld_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr_rd_sched.sv
// ============================================================================
// Module  : tb_ddr_rd_sched
// Purpose : Directed self-checking bench for ddr_rd_sched.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_ddr_rd_sched;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    ddr_rd_sched_if bus ();

    ddr_rd_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_gnt",      128'(bus.gnt),        128'h0);
        chk("rst_dat_vld",  128'(bus.dat_vld),    128'h0);
        chk("rst_cmd_vld",  128'(bus.rd_cmd_vld), 128'h0);
        chk("rst_dat_rdy",  128'(bus.rd_dat_rdy), 128'h0);
        chk("rst_cfg_vld",  128'(bus.cfg_vld),    128'h0);
        chk("rst_cfg_word", bus.cfg_word,         128'h0);
        chk("rst_dat_last", 128'(bus.dat_last),   128'h0);
    endtask

    task automatic cfg_fetch(input logic [127:0] d);
        chk("cfg_cmd_vld",  128'(bus.rd_cmd_vld),  128'h1);
        chk("cfg_cmd_addr", 128'(bus.rd_cmd_addr), 128'h0800_0000);
        chk("cfg_cmd_len",  128'(bus.rd_cmd_len),  128'h0);
        bus.rd_cmd_rdy = 1'b1;
        #1;
        tick();
        bus.rd_cmd_rdy = 1'b0;
        #1;
        chk("cfg_dat_rdy",  128'(bus.rd_dat_rdy),  128'h1);
        bus.rd_dat_vld = 1'b1;
        bus.rd_dat     = d;
        #1;
        tick();
        bus.rd_dat_vld = 1'b0;
        #1;
        chk("cfg_word",     bus.cfg_word,          d);
        chk("cfg_vld",      128'(bus.cfg_vld),     128'h1);
    endtask

    task automatic do_cfg(input logic [127:0] d);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        cfg_fetch(d);
    endtask

    // Grant, command and full burst; stall>0 also drops req after grant
    task automatic burst(input logic [3:0] rq, input logic [7:0] ln, input int g,
                         input logic [31:0] addr, input int stall);
        logic [3:0]   oh;
        logic [127:0] exp_d;
        oh = 4'b0001 << g;
        bus.req     = rq;
        bus.req_len = {4{ln}};
        #1;
        tick();
        chk("gnt",      128'(bus.gnt),         128'(oh));
        chk("cmd_vld",  128'(bus.rd_cmd_vld),  128'h1);
        chk("cmd_addr", 128'(bus.rd_cmd_addr), 128'(addr));
        chk("cmd_len",  128'(bus.rd_cmd_len),  128'(ln));
        if (stall > 0) bus.req = 4'b0000;
        bus.rd_cmd_rdy = 1'b1;
        #1;
        tick();
        bus.rd_cmd_rdy = 1'b0;
        for (int b = 0; b <= int'(ln); b++) begin
            exp_d          = {addr, 32'(b), 64'h0123_4567_89AB_CDEF};
            bus.rd_dat_vld = 1'b1;
            bus.rd_dat     = exp_d;
            if (b == 1) begin
                for (int s = 0; s < stall; s++) begin
                    bus.dat_rdy = 4'h0;
                    #1;
                    chk("stall_rdy",  128'(bus.rd_dat_rdy), 128'h0);
                    chk("stall_last", 128'(bus.dat_last),   128'h0);
                    tick();
                end
            end
            bus.dat_rdy = 4'hF;
            #1;
            chk("dat_vld",    128'(bus.dat_vld),    128'(oh));
            chk("dat",        bus.dat,              exp_d);
            chk("dat_last",   128'(bus.dat_last),   128'(b == int'(ln)));
            chk("rd_dat_rdy", 128'(bus.rd_dat_rdy), 128'h1);
            tick();
        end
        bus.rd_dat_vld = 1'b0;
        #1;
        chk("gnt_clr", 128'(bus.gnt), 128'h0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.req        = '0;
        bus.req_len    = '0;
        bus.dat_rdy    = '0;
        bus.rd_cmd_rdy = 1'b0;
        bus.rd_dat_vld = 1'b0;
        bus.rd_dat     = '0;
        tick();
        tick();
        chk_reset_outs();
        rst = 1'b0;
        bus.rd_dat_vld = 1'b1;
        #1;
        chk("idle_ignore_rdy", 128'(bus.rd_dat_rdy), 128'h0);
        tick();
        bus.rd_dat_vld = 1'b0;

        do_cfg(128'hA5);

        // Round robin with all requests held from a fresh start
        burst(4'b1111, 8'd0, 0, 32'h0800_1000, 0);
        burst(4'b1111, 8'd0, 1, 32'h0840_0000, 0);
        burst(4'b1111, 8'd0, 2, 32'h0841_0000, 0);
        burst(4'b1111, 8'd0, 3, 32'h0881_0000, 0);
        burst(4'b1111, 8'd0, 0, 32'h0800_1010, 0);
        bus.req = 4'b0000;

        // Restart: pointers and priority back to initial values
        do_cfg(128'h77);
        burst(4'b0001, 8'd3, 0, 32'h0800_1000, 0);
        burst(4'b0001, 8'd3, 0, 32'h0800_1040, 0);
        burst(4'b0100, 8'd3, 2, 32'h0841_0000, 5);

        // Abort with two beats still outstanding
        bus.req     = 4'b0001;
        bus.req_len = {4{8'd3}};
        #1;
        tick();
        chk("ab_gnt",  128'(bus.gnt),         128'h1);
        chk("ab_addr", 128'(bus.rd_cmd_addr), 128'h0800_1080);
        bus.rd_cmd_rdy = 1'b1;
        #1;
        tick();
        bus.rd_cmd_rdy = 1'b0;
        bus.req        = 4'b0000;
        bus.dat_rdy    = 4'hF;
        bus.rd_dat_vld = 1'b1;
        tick();
        tick();
        bus.rd_dat_vld = 1'b0;
        bus.start      = 1'b1;
        #1;
        tick();
        bus.start = 1'b0;
        #1;
        chk("ab_cmd_vld0", 128'(bus.rd_cmd_vld), 128'h0);
        chk("ab_drain_rdy", 128'(bus.rd_dat_rdy), 128'h1);
        chk("ab_gnt_clr",  128'(bus.gnt),        128'h0);
        chk("ab_cfg_vld",  128'(bus.cfg_vld),    128'h0);
        bus.rd_dat_vld = 1'b1;
        bus.rd_dat     = 128'hDEAD;
        #1;
        chk("ab_dat_vld",  128'(bus.dat_vld),    128'h0);
        tick();
        chk("ab_cmd_vld1", 128'(bus.rd_cmd_vld), 128'h0);
        chk("ab_drain_rdy1", 128'(bus.rd_dat_rdy), 128'h1);
        tick();
        bus.rd_dat_vld = 1'b0;
        #1;
        cfg_fetch(128'h5A);
        burst(4'b0001, 8'd0, 0, 32'h0800_1000, 0);

        // Reset in the middle of a burst
        bus.req     = 4'b0001;
        bus.req_len = {4{8'd3}};
        #1;
        tick();
        bus.rd_cmd_rdy = 1'b1;
        #1;
        tick();
        bus.rd_cmd_rdy = 1'b0;
        bus.rd_dat_vld = 1'b1;
        tick();
        rst            = 1'b1;
        bus.rd_cmd_rdy = 1'b1;
        #1;
        chk_reset_outs();
        tick();
        rst            = 1'b0;
        bus.rd_dat_vld = 1'b0;
        bus.rd_cmd_rdy = 1'b0;
        bus.req        = 4'b0000;
        #1;
        chk("post_rst_cmd", 128'(bus.rd_cmd_vld), 128'h0);
        do_cfg(128'hA5);
        burst(4'b0001, 8'd3, 0, 32'h0800_1000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
